q6_11_to_e3m4_converter: RTL and testbench

//  Converts a signed Q6.11 fixed-point sample (18b, 11 fractional bits) to FP8 E3M4
//  (sign, 3b exponent bias 3, 4b mantissa, no subnormals/Inf/NaN).

---
 rtl/fp8_pkg.sv | 29 ++
 rtl/lead_one_detect.sv | 21 ++
 rtl/q6_11_to_e3m4_converter.sv | 136 +++++++++++++
 tb/tb_q6_11_to_e3m4_converter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp8_pkg.sv
// Shared E3M4 / Q6.11 constants and the packed FP8 word used by the converter.
package fp8_pkg;

    localparam int unsigned EXP_W    = 3;
    localparam int unsigned MAN_W    = 4;
    localparam int unsigned EXP_BIAS = 3;
    localparam int unsigned Q_W      = 18;
    localparam int unsigned Q_FRAC   = 11;
    localparam int unsigned POS_W    = 5;
    localparam int unsigned FP8_W    = 1 + EXP_W + MAN_W;

    localparam logic [EXP_W+MAN_W-1:0] FP8_MAX_MAG = 7'h7F;

    // Leading-one index that maps to biased exponent 0; below it everything flushes.
    localparam int unsigned E_OFF   = Q_FRAC - EXP_BIAS;
    // First leading-one index whose exponent no longer fits in EXP_W bits.
    localparam int unsigned SAT_POS = E_OFF + (1 << EXP_W);

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
    } e3m4_t;

    function automatic e3m4_t fp8_max(input logic s);
        return e3m4_t'({s, FP8_MAX_MAG});
    endfunction

endpackage

// File: rtl/lead_one_detect.sv
// Priority encoder: index of the most significant set bit of an 18b magnitude.
module lead_one_detect
    import fp8_pkg::*;
(
    input  logic [Q_W-1:0]   a,
    output logic [POS_W-1:0] pos_c,
    output logic             nonzero_c
);

    always_comb begin
        pos_c     = '0;
        nonzero_c = 1'b0;
        for (int i = 0; i < int'(Q_W); i++) begin
            if (a[i]) begin
                pos_c     = POS_W'(i);
                nonzero_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/q6_11_to_e3m4_converter.sv
// Signed Q6.11 -> FP8 E3M4 with round-to-nearest-even, flush-to-zero and saturation.
module q6_11_to_e3m4_converter
    import fp8_pkg::*;
#(
    parameter int unsigned PIPE_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [Q_W-1:0]   q,
    output logic             out_valid,
    output logic [FP8_W-1:0] fp,
    output logic             is_zero,
    output logic             underflow,
    output logic             saturate
);

    localparam int unsigned EW1       = EXP_W + 1;
    localparam int unsigned MW1       = MAN_W + 1;
    localparam int unsigned GUARD_BIT = Q_W - 2 - MAN_W;

    // Stage A: sign/magnitude split and leading-one detect.
    logic             sign_a;
    logic [Q_W-1:0]   mag_a;
    logic [POS_W-1:0] pos_a;
    logic             nz_a;

    always_comb begin
        sign_a = q[Q_W-1];
        mag_a  = sign_a ? (~q + Q_W'(1)) : q;
    end

    lead_one_detect u_lod (
        .a         (mag_a),
        .pos_c     (pos_a),
        .nonzero_c (nz_a)
    );

    // Optional register between detect and round/pack.
    logic             v_b;
    logic             s_b;
    logic [Q_W-1:0]   mag_b;
    logic [POS_W-1:0] pos_b;
    logic             nz_b;

    if (PIPE_STAGES == 2) begin : g_pipe2
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_b   <= 1'b0;
                s_b   <= 1'b0;
                mag_b <= '0;
                pos_b <= '0;
                nz_b  <= 1'b0;
            end else begin
                v_b <= in_valid;
                if (in_valid) begin
                    s_b   <= sign_a;
                    mag_b <= mag_a;
                    pos_b <= pos_a;
                    nz_b  <= nz_a;
                end
            end
        end
    end else begin : g_pipe1
        always_comb begin
            v_b   = in_valid;
            s_b   = sign_a;
            mag_b = mag_a;
            pos_b = pos_a;
            nz_b  = nz_a;
        end
    end

    // Stage B: normalise so the leading one sits at the MSB, then round and pack.
    logic [Q_W-1:0]       norm_c;
    logic                 unused_lead_c;
    logic [MAN_W-1:0]     man_c;
    logic                 guard_c;
    logic                 sticky_c;
    logic                 round_c;
    logic [MW1-1:0]       man_rnd_c;
    logic [EW1-1:0]       exp_c;
    e3m4_t                res_c;
    logic                 zero_c;
    logic                 uflow_c;
    logic                 sat_c;

    always_comb begin
        res_c   = '0;
        zero_c  = 1'b0;
        uflow_c = 1'b0;
        sat_c   = 1'b0;

        norm_c        = mag_b << (POS_W'(Q_W - 1) - pos_b);
        unused_lead_c = norm_c[Q_W-1];
        man_c         = norm_c[Q_W-2 -: MAN_W];
        guard_c       = norm_c[GUARD_BIT];
        sticky_c      = |norm_c[GUARD_BIT-1:0];
        round_c       = guard_c & (sticky_c | man_c[0]);
        man_rnd_c     = {1'b0, man_c} + MW1'(round_c);
        exp_c         = {1'b0, EXP_W'(pos_b - POS_W'(E_OFF))} + EW1'(man_rnd_c[MAN_W]);

        if (!nz_b) begin
            zero_c = 1'b1;
        end else if (pos_b <= POS_W'(E_OFF)) begin
            uflow_c = 1'b1;
        end else if (pos_b >= POS_W'(SAT_POS) || exp_c[EXP_W]) begin
            sat_c = 1'b1;
            res_c = fp8_max(s_b);
        end else begin
            res_c.s = s_b;
            res_c.e = exp_c[EXP_W-1:0];
            res_c.m = man_rnd_c[MAN_W-1:0];
        end
    end

    // Output register: results load only on valid samples and hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            fp        <= '0;
            is_zero   <= 1'b0;
            underflow <= 1'b0;
            saturate  <= 1'b0;
        end else begin
            out_valid <= v_b;
            if (v_b) begin
                fp        <= res_c;
                is_zero   <= zero_c;
                underflow <= uflow_c;
                saturate  <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_q6_11_to_e3m4_converter.sv
// Scoreboard bench driving one 1-stage and one 2-stage converter from shared stimulus.
module tb_q6_11_to_e3m4_converter;

    localparam int P1 = 1;
    localparam int P2 = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [17:0] q;
    logic        ov1, z1, u1, s1;
    logic        ov2, z2, u2, s2;
    logic [7:0]  fp1, fp2;

    always #5 clk = ~clk;

    q6_11_to_e3m4_converter #(.PIPE_STAGES(P1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .q(q),
        .out_valid(ov1), .fp(fp1), .is_zero(z1), .underflow(u1), .saturate(s1)
    );

    q6_11_to_e3m4_converter #(.PIPE_STAGES(P2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .q(q),
        .out_valid(ov2), .fp(fp2), .is_zero(z2), .underflow(u2), .saturate(s2)
    );

    typedef struct {
        logic [17:0] qv;
        logic [7:0]  fp;
        logic        z, u, s;
        int          cyc;
    } sb_t;

    sb_t         sb1[$];
    sb_t         sb2[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        rst_q   = 1'b0;
    logic [10:0] last1   = '0;
    logic [10:0] last2   = '0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    // Reference: nearest representable E3M4 magnitude by exhaustive search, ties to even mantissa.
    function automatic sb_t model(input logic [17:0] qv);
        sb_t    r;
        longint x, a, d, bd, v;
        int     be, bm;
        logic   sg;
        r.qv = qv; r.fp = 8'h00; r.z = 1'b0; r.u = 1'b0; r.s = 1'b0; r.cyc = 0;
        x  = longint'($signed(qv));
        sg = (x < 0);
        a  = sg ? -x : x;
        bd = -1; be = 0; bm = 0;
        if (a == 0) begin
            r.z = 1'b1;
        end else if (a < 2048 / 4) begin
            r.u = 1'b1;
        end else if (a >= (63 * 2048) / 2) begin
            r.s  = 1'b1;
            r.fp = {sg, 7'h7F};
        end else begin
            for (int e = 1; e <= 7; e++) begin
                for (int m = 0; m < 16; m++) begin
                    v = longint'(16 + m) <<< (e + 4);
                    d = (a > v) ? a - v : v - a;
                    if (bd < 0 || d < bd || (d == bd && (m % 2) == 0)) begin
                        bd = d; be = e; bm = m;
                    end
                end
            end
            r.fp = {sg, 3'(be), 4'(bm)};
        end
        return r;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc=%0d: got %h want %h", name, d, cyc, act, exp);
        end
    endtask

    task automatic mon(input int d, input logic ov, input logic [7:0] f,
                       input logic z, input logic u, input logic s);
        sb_t         e;
        logic [10:0] got;
        longint      a, v;
        got = {f, z, u, s};
        if (!rst_q) begin
            chk("reset_state", d, {20'd0, ov, got}, 32'd0);
            if (d == 1) last1 = '0; else last2 = '0;
            return;
        end
        if (!ov) begin
            chk("hold", d, {21'd0, got}, {21'd0, (d == 1) ? last1 : last2});
            return;
        end
        if ((d == 1 && sb1.size() == 0) || (d == 2 && sb2.size() == 0)) begin
            chk("unexpected_valid", d, 32'd1, 32'd0);
            return;
        end
        e = (d == 1) ? sb1.pop_front() : sb2.pop_front();
        chk("fp_flags", d, {21'd0, got}, {21'd0, e.fp, e.z, e.u, e.s});
        chk("latency", d, cyc, e.cyc + d);
        if (!e.z && !e.u && !e.s && f[6:4] != 3'd0) begin
            a = longint'($signed(e.qv));
            if (a < 0) a = -a;
            v = longint'(16 + int'(f[3:0])) <<< (int'(f[6:4]) + 4);
            chk("rel_err", d, {31'd0, (((v > a) ? v - a : a - v) * 32) <= a}, 32'd1);
        end
        if (d == 1) last1 = got; else last2 = got;
    endtask

    always @(negedge clk) begin
        mon(1, ov1, fp1, z1, u1, s1);
        mon(2, ov2, fp2, z2, u2, s2);
    end

    task automatic send_ex(input logic [17:0] v, input logic vld, input sb_t e,
                           input bit p1, input bit p2);
        sb_t t;
        q        = v;
        in_valid = vld;
        t        = e;
        t.cyc    = cyc;
        if (vld && p1) sb1.push_back(t);
        if (vld && p2) sb2.push_back(t);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [17:0] v, input logic vld);
        send_ex(v, vld, model(v), 1'b1, 1'b1);
    endtask

    task automatic send_dir(input int v, input logic [7:0] f, input logic z,
                            input logic u, input logic s);
        sb_t e;
        e.qv = 18'(v); e.fp = f; e.z = z; e.u = u; e.s = s; e.cyc = 0;
        send_ex(18'(v), 1'b1, e, 1'b1, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(18'd0, 1'b0);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((sb1.size() != 0 || sb2.size() != 0) && k < 20) begin
            idle(1);
            k++;
        end
        chk(name, 0, sb1.size() + sb2.size(), 32'd0);
    endtask

    logic [17:0] rv;
    int          mode;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; q = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);

        // Directed points with hand-derived encodings.
        send_dir(2048,    8'h30, 0, 0, 0);
        send_dir(-2048,   8'hB0, 0, 0, 0);
        send_dir(3072,    8'h38, 0, 0, 0);
        send_dir(512,     8'h10, 0, 0, 0);
        send_dir(511,     8'h00, 0, 1, 0);
        send_dir(0,       8'h00, 1, 0, 0);
        send_dir(2112,    8'h30, 0, 0, 0);
        send_dir(2113,    8'h31, 0, 0, 0);
        send_dir(2240,    8'h32, 0, 0, 0);
        send_dir(4032,    8'h40, 0, 0, 0);
        send_dir(63488,   8'h7F, 0, 0, 0);
        send_dir(64512,   8'h7F, 0, 0, 1);
        send_dir(65536,   8'h7F, 0, 0, 1);
        send_dir(-131072, 8'hFF, 0, 0, 1);
        send_dir(-511,    8'h00, 0, 1, 0);
        idle(3);

        // Back-to-back then a gap: order, latency and hold.
        send(18'd1, 1'b1);
        send(18'd2, 1'b1);
        send(18'd3, 1'b1);
        idle(4);
        drain("drain_b2b");

        // Randomised traffic biased toward boundaries, with random bubbles.
        for (int i = 0; i < 3000; i++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: rv = 18'($urandom);
                1: rv = 18'($urandom_range(0, 1100));
                2: rv = 18'($urandom_range(62000, 66500));
                default: rv = 18'($urandom_range(0, 8191) << $urandom_range(0, 5));
            endcase
            if ($urandom_range(0, 1) == 1) rv = ~rv + 18'd1;
            send(rv, ($urandom_range(0, 3) != 0));
        end
        drain("drain_random");

        // Reset right behind a sample: only the 1-stage copy has already produced it.
        send_ex(18'd2048, 1'b1, model(18'd2048), 1'b1, 1'b0);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(4);
        chk("reset_flush", 0, sb1.size() + sb2.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
